// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the bus-attached multiplier master: operand and
// product widths, the default WAIT timeout, the timeout counter width and the
// controller state encoding.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int BYTE_W          = 8;   // operand / bus byte width
    localparam int PROD_W          = 16;  // product width {msb byte, lsb byte}
    localparam int CTR_W           = 8;   // timeout counter width (TIMEOUT <= 255)
    localparam int TIMEOUT_DEFAULT = 64;  // WAIT cycles allowed before abort

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/mult_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mult_timeout_ctr
// Counts enabled cycles since the last clear. 'expired' is high during the
// enabled cycle that is the limit-th one since the clear, so the owner can
// leave its waiting state on the very cycle the allowance runs out.
//
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero the count (takes priority over enable)
//   enable     : count this cycle
//   limit      : number of enabled cycles allowed (>= 1)
//   expired    : current enabled cycle is the last one allowed
// -----------------------------------------------------------------------------
module mult_timeout_ctr
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CTR_W-1:0] limit,
    output logic             expired
);

    logic [CTR_W-1:0] count;

    // NOTE: registers are written with <= so every flop samples pre-edge values;
    // blocking assignments here would make later reads see post-edge data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // The count holds the number of cycles already spent, so the final allowed
    // cycle is the one where count has reached limit-1.
    assign expired = enable && (count >= (limit - 1'b1));

endmodule

// File: rtl/mult_bus_master.sv
// -----------------------------------------------------------------------------
// mult_bus_master
// Drives an external byte-serial multiplier over a shared 8-bit bus. An
// accepted operand pair is sent as A (with a one-cycle start pulse) then B;
// the multiplier later returns the product one byte at a time, flagged by
// lsb_out / msb_out, and finishes with done. The result is held until taken.
// A missing byte, both strobes at once, or no done within TIMEOUT WAIT cycles
// marks the result as errored.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake, in_a/in_b unsigned bytes
//   out_valid/out_ready   : result handshake, out_product/out_err
//   start                 : one-cycle pulse while A is on the bus
//   databus               : shared bidirectional byte bus
//   lsb_out/msb_out       : multiplier is driving the low/high product byte
//   done                  : multiplier finished
// -----------------------------------------------------------------------------
module mult_bus_master
    import mult_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              out_err,
    output logic              start,
    inout  wire  [BYTE_W-1:0] databus,
    input  logic              lsb_out,
    input  logic              msb_out,
    input  logic              done
);

    localparam logic [CTR_W-1:0] TIMEOUT_LIMIT = CTR_W'(TIMEOUT);

    state_t              state, state_next;
    logic [BYTE_W-1:0]   a_q, b_q, bus_data;
    logic                bus_oe;
    logic [PROD_W-1:0]   product_q;
    logic                lsb_seen, msb_seen, fault, err_q;
    logic                lsb_seen_next, msb_seen_next, fault_next;
    logic                in_wait, accept, cap_lsb, cap_msb, clash;
    logic                ctr_clear, ctr_en, expired;

    mult_timeout_ctr u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .limit   (TIMEOUT_LIMIT),
        .expired (expired)
    );

    // Strobes only mean something while waiting; both at once is a protocol
    // fault and captures nothing.
    assign in_wait = (state == WAIT);
    assign accept  = (state == IDLE) && in_valid;
    assign cap_lsb = in_wait && lsb_out && !msb_out;
    assign cap_msb = in_wait && msb_out && !lsb_out;
    assign clash   = in_wait && lsb_out && msb_out;

    // Flag values including this cycle's strobe, so a byte arriving together
    // with done still counts towards the error verdict.
    assign lsb_seen_next = lsb_seen | cap_lsb;
    assign msb_seen_next = msb_seen | cap_msb;
    assign fault_next    = fault | clash;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        start      = 1'b0;
        bus_oe     = 1'b0;
        bus_data   = a_q;
        ctr_clear  = 1'b0;
        ctr_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SEND_A;
            end
            SEND_A: begin
                start      = 1'b1;
                bus_oe     = 1'b1;
                bus_data   = a_q;
                state_next = SEND_B;
            end
            SEND_B: begin
                bus_oe     = 1'b1;
                bus_data   = b_q;
                ctr_clear  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                ctr_en = 1'b1;
                if (done || expired) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            lsb_seen  <= 1'b0;
            msb_seen  <= 1'b0;
            fault     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q      <= in_a;
                b_q      <= in_b;
                lsb_seen <= 1'b0;
                msb_seen <= 1'b0;
                fault    <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                lsb_seen <= lsb_seen_next;
                msb_seen <= msb_seen_next;
                fault    <= fault_next;
            end
            if (cap_lsb) product_q[BYTE_W-1:0]      <= databus;
            if (cap_msb) product_q[PROD_W-1:BYTE_W] <= databus;
            // Leaving WAIT without done can only be the timeout.
            if (in_wait && (state_next == HOLD)) begin
                err_q <= !done || fault_next || !lsb_seen_next || !msb_seen_next;
            end
        end
    end

    assign databus     = bus_oe ? bus_data : {BYTE_W{1'bz}};
    assign out_product = product_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_mult_bus_master.sv
// -----------------------------------------------------------------------------
// tb_mult_bus_master
// Drives mult_bus_master with directed and randomized operations. A multiplier
// responder answers on the shared bus with scripted byte strobes; a
// transaction-level model tracks what the master must present each cycle and
// a negedge compare process checks the DUT against it.
// -----------------------------------------------------------------------------
module tb_mult_bus_master;
    import mult_pkg::*;

    localparam int TO         = TIMEOUT_DEFAULT;
    localparam int M_NORMAL   = 0;
    localparam int M_FIXED    = 1;
    localparam int M_LSB_ONLY = 2;
    localparam int M_BOTH     = 3;
    localparam int M_NEVER    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [7:0]  in_a, in_b;
    logic        out_valid, out_ready;
    logic [15:0] out_product;
    logic        out_err, start;
    logic        lsb_out, msb_out, done;
    wire  [7:0]  databus;

    logic        tb_oe;
    logic [7:0]  tb_dq;
    assign databus = tb_oe ? tb_dq : 8'hzz;

    int n_checks = 0;
    int n_errors = 0;
    int mode     = M_NORMAL;
    bit junk_en  = 1'b0;

    always #5 clk = ~clk;

    mult_bus_master #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_err     (out_err),
        .start       (start),
        .databus     (databus),
        .lsb_out     (lsb_out),
        .msb_out     (msb_out),
        .done        (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- multiplier responder ----------------
    typedef struct packed {
        logic       l;
        logic       m;
        logic       d;
        logic [7:0] v;
    } step_t;

    function automatic step_t mk(input logic l, input logic m, input logic d, input logic [7:0] v);
        step_t s;
        s.l = l; s.m = m; s.d = d; s.v = v;
        return s;
    endfunction

    task automatic junk_strobes();
        tb_oe   = 1'b0;
        lsb_out = junk_en && ($urandom_range(0, 3) == 0);
        msb_out = junk_en && ($urandom_range(0, 3) == 0);
        done    = junk_en && ($urandom_range(0, 3) == 0);
    endtask

    initial begin : responder
        logic [7:0]  ra, rb;
        logic [15:0] p;
        logic        lo_first;
        step_t       q[$];
        step_t       s;
        tb_oe = 1'b0; tb_dq = 8'h00; lsb_out = 1'b0; msb_out = 1'b0; done = 1'b0;
        forever begin
            @(posedge clk); #1;
            junk_strobes();
            if (rst_n && start) begin
                ra = databus;
                @(posedge clk); #1;
                junk_strobes();
                rb = databus;
                p  = 16'(ra) * 16'(rb);
                q.delete();
                case (mode)
                    M_FIXED: begin
                        q.push_back(mk(1'b1, 1'b0, 1'b0, p[7:0]));
                        q.push_back(mk(1'b0, 1'b1, 1'b0, p[15:8]));
                        q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00));
                    end
                    M_NORMAL: begin
                        lo_first = 1'($urandom_range(0, 1));
                        repeat ($urandom_range(0, 3)) q.push_back('0);
                        q.push_back(lo_first ? mk(1'b1, 1'b0, 1'b0, p[7:0]) : mk(1'b0, 1'b1, 1'b0, p[15:8]));
                        repeat ($urandom_range(0, 3)) q.push_back('0);
                        q.push_back(lo_first ? mk(1'b0, 1'b1, 1'b0, p[15:8]) : mk(1'b1, 1'b0, 1'b0, p[7:0]));
                        if ($urandom_range(0, 1) == 1) begin
                            s = q.pop_back();
                            s.d = 1'b1;
                            q.push_back(s);
                        end else begin
                            repeat ($urandom_range(0, 3)) q.push_back('0);
                            q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00));
                        end
                    end
                    M_LSB_ONLY: begin
                        repeat ($urandom_range(0, 2)) q.push_back('0);
                        q.push_back(mk(1'b1, 1'b0, 1'b0, p[7:0]));
                        repeat ($urandom_range(0, 2)) q.push_back('0);
                        q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00));
                    end
                    M_BOTH: begin
                        q.push_back(mk(1'b1, 1'b1, 1'b0, p[7:0]));
                        q.push_back(mk(1'b1, 1'b0, 1'b0, p[7:0]));
                        q.push_back(mk(1'b0, 1'b1, 1'b0, p[15:8]));
                        q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00));
                    end
                    default: ;
                endcase
                // Own the bus through WAIT (holding 0x00 between bytes) until
                // the master leaves it.
                for (int i = 0; i < 4 * TO; i++) begin
                    @(posedge clk); #1;
                    if (out_valid || in_ready) break;
                    s = (q.size() > 0) ? q.pop_front() : step_t'('0);
                    tb_oe = 1'b1; tb_dq = s.v;
                    lsb_out = s.l; msb_out = s.m; done = s.d;
                end
                tb_oe = 1'b0; lsb_out = 1'b0; msb_out = 1'b0; done = 1'b0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // age: 1 = A on bus, 2 = B on bus, 3 = waiting for the multiplier.
    bit         live = 1'b0;
    bit         m_busy, m_hold, m_err, m_lo, m_hi, m_bad;
    int         m_age, m_wait;
    logic [7:0] ma, mb;

    always @(posedge clk) begin
        if (!rst_n) begin
            live = 1'b1; m_busy = 1'b0; m_hold = 1'b0; m_age = 0; m_err = 1'b0;
        end else if (live) begin
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1; m_age = 1; ma = in_a; mb = in_b;
                    m_lo = 1'b0; m_hi = 1'b0; m_bad = 1'b0; m_wait = 0;
                end
            end else if (m_hold) begin
                if (out_ready) begin
                    m_busy = 1'b0; m_hold = 1'b0;
                end
            end else if (m_age < 3) begin
                m_age++;
            end else begin
                if (lsb_out && msb_out) m_bad = 1'b1;
                else if (lsb_out)       m_lo  = 1'b1;
                else if (msb_out)       m_hi  = 1'b1;
                m_wait++;
                if (done) begin
                    m_hold = 1'b1; m_err = m_bad || !m_lo || !m_hi;
                end else if (m_wait == TO) begin
                    m_hold = 1'b1; m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live && rst_n) begin
            check("in_ready", 32'(in_ready), 32'(!m_busy));
            check("start", 32'(start), 32'(m_busy && !m_hold && m_age == 1));
            check("out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) begin
                check("out_err", 32'(out_err), 32'(m_err));
                if (!m_err) check("out_product", 32'(out_product), 32'(16'(ma) * 16'(mb)));
            end
            if (m_busy && !m_hold) begin
                if (m_age == 1)      check("bus_a", 32'(databus), 32'(ma));
                else if (m_age == 2) check("bus_b", 32'(databus), 32'(mb));
                else if (tb_oe)      check("bus_wait_undriven", 32'(databus), 32'(tb_dq));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid(input string name, output int n, output bit ok);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL %s_wait: out_valid not seen within 300 cycles", name);
        end
    endtask

    task automatic wait_start(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL %s_wait: start not seen within 300 cycles", name);
        end
    endtask

    // Issue one operation from IDLE, hold the result 'hold' cycles, then take it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit pin,
                          input logic [15:0] exp_p, input bit exp_e, input int exp_lat,
                          input string name);
        int n;
        bit ok;
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(name, n, ok);
        if (ok) begin
            if (pin) begin
                if (exp_lat >= 0) check({name, "_latency"}, 32'(n), 32'(exp_lat));
                check({name, "_err"}, 32'(out_err), 32'(exp_e));
                if (!exp_e) check({name, "_product"}, 32'(out_product), 32'(exp_p));
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (pin) begin
                    check({name, "_hold_in_ready"}, 32'(in_ready), 0);
                    check({name, "_hold_valid"}, 32'(out_valid), 1);
                    if (!exp_e) check({name, "_hold_product"}, 32'(out_product), 32'(exp_p));
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] res0, res1;
        int          r;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_err", 32'(out_err), 0);
        check("reset_product", 32'(out_product), 0);
        check("reset_start", 32'(start), 0);

        // 7 x 9: lsb 0x3F, msb 0x00, done on separate WAIT cycles.
        mode = M_FIXED;
        run_op(8'd7, 8'd9, 0, 1'b1, 16'h003F, 1'b0, 5, "op_7x9");

        // 0xFF x 0xFF with the consumer stalling for 5 cycles.
        mode = M_NORMAL;
        run_op(8'hFF, 8'hFF, 5, 1'b1, 16'hFE01, 1'b0, -1, "op_ffxff");

        // No done: 2 send cycles + TO WAIT cycles, then errored result.
        mode = M_NEVER;
        run_op(8'd5, 8'd6, 2, 1'b1, 16'h0000, 1'b1, 2 + TO, "op_timeout");

        mode = M_LSB_ONLY;
        run_op(8'h12, 8'h34, 0, 1'b1, 16'h0000, 1'b1, -1, "op_lsb_only");

        mode = M_BOTH;
        run_op(8'h21, 8'h43, 0, 1'b1, 16'h0000, 1'b1, -1, "op_both_strobes");

        // Reset while B is on the bus.
        mode = M_NORMAL;
        in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hC3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mid_send_a_start", 32'(start), 1);
        @(posedge clk); #1;
        check("rst_mid_send_b_start", 32'(start), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_in_ready", 32'(in_ready), 1);
        check("rst_mid_start", 32'(start), 0);
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_mid_out_err", 32'(out_err), 0);
        check("rst_mid_product", 32'(out_product), 0);
        run_op(8'd3, 8'd4, 0, 1'b1, 16'h000C, 1'b0, -1, "op_3x4_after_rst");

        // Back-to-back with out_ready tied high and in_valid held.
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
        wait_start("b2b_first");
        in_a = 8'd16; in_b = 8'd16;
        wait_valid_capture : begin
            int n; bit ok;
            wait_valid("b2b_first", n, ok);
            res0 = out_product;
            wait_start("b2b_second");
            in_valid = 1'b0;
            @(posedge clk); #1;
            wait_valid("b2b_second", n, ok);
            res1 = out_product;
        end
        check("b2b_first_product", 32'(res0), 32'h0006);
        check("b2b_second_product", 32'(res1), 32'h0100);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_idle_after", 32'(in_ready), 1);

        // Randomized operations with junk strobes outside WAIT.
        junk_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 5);
            mode = (r < 4) ? M_NORMAL : ((r == 4) ? M_LSB_ONLY : M_BOTH);
            run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0, 16'h0000, 1'b0, -1, "rand");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        junk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_bus_master.md
MULT_BUS_MASTER -- requirements
Module: mult_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum cycles in WAIT before abort (range 4..255).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operand pair.
REQ-006 SHALL have ports in_a, in_b  input  8 each  multiplicand and multiplier, unsigned.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  consumer takes result.
REQ-009 SHALL have port out_product  output  16  captured product {msb byte, lsb byte}.
REQ-010 SHALL have port out_err  output  1  result invalid (timeout or protocol fault), qualified by out_valid.
REQ-011 SHALL have port start  output  1  one-cycle start pulse to the multiplier.
REQ-012 SHALL have port databus  inout  8  shared operand/result bus.
REQ-013 SHALL have ports lsb_out, msb_out  input  1 each  multiplier drives low/high product byte on databus this cycle.
REQ-014 SHALL have port done  input  1  multiplier finished.

Function
REQ-015 SHALL implement states IDLE, SEND_A, SEND_B, WAIT, HOLD.
REQ-016 IDLE: in_ready=1; on in_valid register in_a/in_b, clear capture flags, go SEND_A.
REQ-017 SEND_A: start=1, databus driven with registered A; next cycle SEND_B.
REQ-018 SEND_B: start=0, databus driven with registered B; next cycle WAIT, timeout counter cleared.
REQ-019 databus SHALL be high-impedance in every state except SEND_A and SEND_B.
REQ-020 WAIT: lsb_out alone -> capture databus into product[7:0], set lsb flag; msb_out alone -> capture into product[15:8], set msb flag.
REQ-021 lsb_out and msb_out high together SHALL capture nothing and set the fault flag.
REQ-022 A byte strobe and done in the same cycle SHALL capture the byte first, then evaluate done.
REQ-023 done in WAIT -> HOLD; out_err = fault flag OR lsb flag clear OR msb flag clear.
REQ-024 Timeout counter increments each WAIT cycle; reaching TIMEOUT without done -> HOLD with out_err=1.
REQ-025 HOLD: out_valid=1, out_product and out_err stable; on out_ready go IDLE the next cycle.
REQ-026 Strobes or done outside WAIT SHALL be ignored.
REQ-027 in_ready SHALL be 0 in every state except IDLE; at most one operation outstanding.
REQ-028 Latency from in_valid accept to out_valid SHALL be 3 cycles plus the multiplier's done delay.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE from any state, including mid-operation.
REQ-030 Reset values: in_ready=1 (combinational from IDLE), out_valid=0, out_err=0, out_product=0, start=0, databus high-impedance, counter and flags 0.

Structure
REQ-031 State enum, byte width 8, product width 16 and TIMEOUT default SHALL live in shared package mult_pkg.
REQ-032 The WAIT timeout counter SHALL be sub-module mult_timeout_ctr (clear, enable, limit, expired).

Verification
REQ-033 A=7, B=9; model drives lsb 0x3F then msb 0x00, then done -> out_product=0x003F, out_err=0.
REQ-034 A=0xFF, B=0xFF -> out_product=0xFE01, out_err=0; out_ready held low 5 cycles -> result stable, in_ready=0 throughout.
REQ-035 No done within 64 WAIT cycles -> HOLD, out_valid=1, out_err=1; databus never driven in WAIT.
REQ-036 done with only lsb_out seen -> out_err=1; lsb_out and msb_out together -> out_err=1.
REQ-037 rst_n low during SEND_B -> next cycle IDLE, start=0, databus Z, out_valid=0; next op 3x4 -> 0x000C.
REQ-038 Back-to-back ops 2x3 then 16x16, out_ready tied high -> 0x0006 then 0x0100, in order, none lost.
